// File: rtl/sdram_req_pkg.sv
// Shared types for the SDRAM request queue: the buffered request entry,
// the issue-FSM state encoding and the controller read-data width.
package sdram_req_pkg;
  localparam int REQ_ADDR_WIDTH = 25;
  localparam int REQ_DATA_WIDTH = 16;
  localparam int CTRL_Q_WIDTH   = 32;

  typedef struct packed {
    logic                      we;
    logic [REQ_ADDR_WIDTH-1:0] addr;
    logic [REQ_DATA_WIDTH-1:0] data;
    logic [1:0]                byte_en;
  } sdram_req_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_GUARD     = 2'd2,
    ST_WAIT_DONE = 2'd3
  } req_state_e;
endpackage

// File: rtl/sdram_req_queue_if.sv
// Client request/response and controller port-0 signals of the request queue.
// Client handshake: a request transfers on a clock edge with req_valid && req_ready;
// req_valid and its payload must stay stable until that edge, req_ready never depends on req_valid.
interface sdram_req_queue_if
  import sdram_req_pkg::*;
#(
  parameter int ADDR_WIDTH = 25,
  parameter int DATA_WIDTH = 16
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_data;
  logic [1:0]              req_byte_en;
  logic                    resp_valid;
  logic [CTRL_Q_WIDTH-1:0] resp_data;
  logic                    busy;
  logic                    ctrl_init_complete;
  logic                    ctrl_ready;
  logic [CTRL_Q_WIDTH-1:0] ctrl_q;
  logic [ADDR_WIDTH-1:0]   ctrl_addr;
  logic [DATA_WIDTH-1:0]   ctrl_data;
  logic [1:0]              ctrl_byte_en;
  logic                    ctrl_wr_req;
  logic                    ctrl_rd_req;

  // Client and controller side together (drives requests and controller status).
  modport master (
    output req_valid, req_we, req_addr, req_data, req_byte_en,
    output ctrl_init_complete, ctrl_ready, ctrl_q,
    input  req_ready, resp_valid, resp_data, busy,
    input  ctrl_addr, ctrl_data, ctrl_byte_en, ctrl_wr_req, ctrl_rd_req
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_data, req_byte_en,
    input  ctrl_init_complete, ctrl_ready, ctrl_q,
    output req_ready, resp_valid, resp_data, busy,
    output ctrl_addr, ctrl_data, ctrl_byte_en, ctrl_wr_req, ctrl_rd_req
  );
endinterface

// File: rtl/sdram_req_fifo.sv
// Show-ahead synchronous FIFO of request entries; the head is valid whenever empty is low.
module sdram_req_fifo
  import sdram_req_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic                         pop,
  input  sdram_req_t                   push_data,
  output sdram_req_t                   head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  sdram_req_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/sdram_req_queue.sv
// Buffers client requests and issues them one at a time to the SDRAM controller's
// single-cycle request pulses, returning read data as a one-cycle response strobe.
module sdram_req_queue
  import sdram_req_pkg::*;
#(
  parameter int ADDR_WIDTH = 25,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  sdram_req_queue_if.slave  bus,
  output logic [1:0]        dbg_state
);
  localparam logic [1:0] IDLE      = 2'(ST_IDLE);
  localparam logic [1:0] ISSUE     = 2'(ST_ISSUE);
  localparam logic [1:0] GUARD     = 2'(ST_GUARD);
  localparam logic [1:0] WAIT_DONE = 2'(ST_WAIT_DONE);

  logic [1:0]                 state;
  sdram_req_t                 push_entry;
  sdram_req_t                 head;
  logic                       full;
  logic                       empty;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       push;
  logic                       issue;
  logic                       rd_pending;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [DATA_WIDTH-1:0]      data_q;
  logic [1:0]                 byte_en_q;
  logic                       wr_req_q;
  logic                       rd_req_q;
  logic                       resp_valid_q;
  logic [CTRL_Q_WIDTH-1:0]    resp_data_q;

  assign push  = bus.req_valid && !full;
  assign issue = (state == IDLE) && !empty && bus.ctrl_init_complete && bus.ctrl_ready;

  always_comb begin
    push_entry         = '0;
    push_entry.we      = bus.req_we;
    push_entry.addr    = REQ_ADDR_WIDTH'(bus.req_addr);
    push_entry.data    = REQ_DATA_WIDTH'(bus.req_data);
    push_entry.byte_en = bus.req_byte_en;
  end

  sdram_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (issue),
    .push_data (push_entry),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // GUARD exists because the controller drops p0_ready one cycle late; ready is
  // only trusted again from WAIT_DONE onwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      byte_en_q    <= '0;
      wr_req_q     <= 1'b0;
      rd_req_q     <= 1'b0;
      rd_pending   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            state      <= ISSUE;
            addr_q     <= ADDR_WIDTH'(head.addr);
            data_q     <= head.we ? DATA_WIDTH'(head.data) : '0;
            byte_en_q  <= head.byte_en;
            wr_req_q   <= head.we;
            rd_req_q   <= !head.we;
            rd_pending <= !head.we;
          end
        end
        ISSUE: begin
          state    <= GUARD;
          wr_req_q <= 1'b0;
          rd_req_q <= 1'b0;
        end
        GUARD: state <= WAIT_DONE;
        default: begin
          if (bus.ctrl_ready) begin
            state      <= IDLE;
            rd_pending <= 1'b0;
            if (rd_pending) begin
              resp_valid_q <= 1'b1;
              resp_data_q  <= bus.ctrl_q;
            end
          end
        end
      endcase
    end
  end

  assign bus.req_ready    = !full;
  assign bus.busy         = (count != '0) || (state != IDLE);
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_data    = resp_data_q;
  assign bus.ctrl_addr    = addr_q;
  assign bus.ctrl_data    = data_q;
  assign bus.ctrl_byte_en = byte_en_q;
  assign bus.ctrl_wr_req  = wr_req_q;
  assign bus.ctrl_rd_req  = rd_req_q;
  assign dbg_state        = state;
endmodule

// File: tb/tb_sdram_req_queue.sv
// Directed bench for sdram_req_queue: a small controller model plus issue/response scoreboards.
`timescale 1ns/1ps
module tb_sdram_req_queue;
  localparam int AW    = 25;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int EW    = 1 + AW + DW + 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int n_issued = 0;
  int n_resp   = 0;

  logic [EW-1:0] exp_q[$];
  logic [31:0]   resp_exp_q[$];

  logic ctrl_stall = 1'b0;
  int   ctrl_lat   = 2;
  int   ctrl_cnt   = 0;
  logic prev_req   = 1'b0;

  sdram_req_queue_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sdram_req_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] read_model(input logic [AW-1:0] a);
    if (a == 25'h0322020) return 32'h5678_1234;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Controller model: drops ready after each request pulse for ctrl_lat cycles.
  always begin
    @(posedge clk);
    #1;
    if (!reset_n) begin
      ctrl_cnt       = 0;
      prev_req       = 1'b0;
      bus.ctrl_ready = !ctrl_stall;
      bus.ctrl_q     = '0;
    end else begin
      if (bus.ctrl_wr_req || bus.ctrl_rd_req) begin
        check("ready_at_issue", bus.ctrl_ready, 1);
        check("req_onehot", bus.ctrl_wr_req & bus.ctrl_rd_req, 0);
        check("pulse_width", prev_req, 0);
        n_issued++;
        check("issue_expected", exp_q.size() == 0, 0);
        if (exp_q.size() > 0)
          check("issue_entry", {bus.ctrl_wr_req, bus.ctrl_addr, bus.ctrl_data, bus.ctrl_byte_en},
                exp_q.pop_front());
        if (bus.ctrl_rd_req) resp_exp_q.push_back(read_model(bus.ctrl_addr));
        bus.ctrl_q     = read_model(bus.ctrl_addr);
        bus.ctrl_ready = 1'b0;
        ctrl_cnt       = ctrl_lat;
      end else if (ctrl_cnt > 0) begin
        ctrl_cnt--;
      end
      if (ctrl_cnt == 0) bus.ctrl_ready = !ctrl_stall;
      prev_req = bus.ctrl_wr_req | bus.ctrl_rd_req;
      if (bus.resp_valid) begin
        n_resp++;
        check("resp_expected", resp_exp_q.size() == 0, 0);
        if (resp_exp_q.size() > 0) check("resp_data", bus.resp_data, resp_exp_q.pop_front());
      end
    end
  end

  // Called at a negedge; returns at a negedge with req_valid low.
  task automatic push(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [1:0] be);
    int waited = 0;
    while (!bus.req_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) begin
      check("push_ready_timeout", bus.req_ready, 1);
      return;
    end
    bus.req_valid   = 1'b1;
    bus.req_we      = we;
    bus.req_addr    = a;
    bus.req_data    = d;
    bus.req_byte_en = be;
    @(posedge clk);
    exp_q.push_back({we, a, (we ? d : {DW{1'b0}}), be});
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i = 0;
    while ((bus.busy || !bus.ctrl_ready) && i < 500) begin
      @(negedge clk);
      i++;
    end
    check("idle_reached", i < 500, 1);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 1);
    check({tag, "_resp_valid"}, bus.resp_valid, 0);
    check({tag, "_resp_data"}, bus.resp_data, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_wr_req"}, bus.ctrl_wr_req, 0);
    check({tag, "_rd_req"}, bus.ctrl_rd_req, 0);
    check({tag, "_addr"}, bus.ctrl_addr, 0);
    check({tag, "_data"}, bus.ctrl_data, 0);
    check({tag, "_byte_en"}, bus.ctrl_byte_en, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int ib;
    int rb;
    int i;
    bus.req_valid          = 1'b0;
    bus.req_we             = 1'b0;
    bus.req_addr           = '0;
    bus.req_data           = '0;
    bus.req_byte_en        = '0;
    bus.ctrl_init_complete = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset_n = 1'b1;
    @(negedge clk);

    // Init gating
    push(1'b1, 25'h0322020, 16'h1234, 2'h3);
    repeat (6) @(negedge clk);
    check("t1_no_issue", n_issued, 0);
    check("t1_busy", bus.busy, 1);
    check("t1_state_idle", dbg_state, 0);
    bus.ctrl_init_complete = 1'b1;
    wait_idle();
    check("t1_issued", n_issued, 1);

    // Back-to-back writes
    ib = n_issued;
    push(1'b1, 25'h0322020, 16'h1234, 2'h3);
    push(1'b1, 25'h0322022, 16'h5678, 2'h1);
    wait_idle();
    check("t2_issued", n_issued - ib, 2);

    // Read response
    rb = n_resp;
    push(1'b0, 25'h0322020, 16'hFFFF, 2'h2);
    wait_idle();
    check("t3_resp_count", n_resp - rb, 1);
    check("t3_resp_data", bus.resp_data, 32'h5678_1234);
    repeat (3) @(negedge clk);
    check("t3_resp_hold", bus.resp_data, 32'h5678_1234);
    check("t3_resp_low", bus.resp_valid, 0);

    // Full, then refill while draining
    ib = n_issued;
    ctrl_stall = 1'b1;
    repeat (2) @(negedge clk);
    for (i = 0; i < DEPTH; i++) push(1'b1, 25'h0200000 + 25'(i), 16'hB000 + 16'(i), 2'h3);
    check("t4_full_ready", bus.req_ready, 0);
    check("t4_full_busy", bus.busy, 1);
    check("t4_no_issue", n_issued - ib, 0);
    ctrl_stall = 1'b0;
    push(1'b0, 25'h0200010, 16'hCCCC, 2'h1);
    check("t4_refull_ready", bus.req_ready, 0);
    wait_idle();
    check("t4_issued", n_issued - ib, DEPTH + 1);

    // Wrap-around with alternating reads and writes and varying controller latency
    ib = n_issued;
    rb = n_resp;
    for (i = 0; i < 3 * DEPTH; i++) begin
      ctrl_lat = 1 + (i % 3);
      push((i % 2) == 0, 25'h0100000 + 25'(i * 8), 16'hA000 + 16'(i), 2'(i));
    end
    wait_idle();
    check("t5_issued", n_issued - ib, 3 * DEPTH);
    check("t5_resp_count", n_resp - rb, 3 * DEPTH / 2);
    check("t5_exp_q_drained", exp_q.size(), 0);
    check("t5_resp_q_drained", resp_exp_q.size(), 0);

    // Reset during WAIT_DONE with two entries queued
    ctrl_lat = 30;
    push(1'b0, 25'h0300000, 16'h0, 2'h3);
    push(1'b1, 25'h0300002, 16'h1111, 2'h3);
    push(1'b0, 25'h0300004, 16'h0, 2'h3);
    i = 0;
    while (dbg_state != 2'd3 && i < 50) begin
      @(negedge clk);
      i++;
    end
    check("t6_reached_wait", dbg_state, 3);
    check("t6_busy", bus.busy, 1);
    ib = n_issued;
    rb = n_resp;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    exp_q.delete();
    resp_exp_q.delete();
    ctrl_lat = 2;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check("t6_no_stale_issue", n_issued - ib, 0);
    check("t6_no_stale_resp", n_resp - rb, 0);
    check("t6_idle_busy", bus.busy, 0);
    check("t6_idle_state", dbg_state, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
